fft_peak_sched: RTL and testbench

FFT_PEAK_SCHED -- requirements
Module: fft_peak_sched

---
 rtl/fft_pkg.sv | 30 +++
 rtl/fft_peak_sched_peak_tracker.sv | 59 +++++
 rtl/fft_peak_sched.sv | 185 ++++++++++++++++++
 tb/tb_fft_peak_sched.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg -- shared types and defaults for the FFT peak scheduler.
//   fsm_state_t    : capture/search controller states
//   *_DEF          : default parameter values for the frame, ADC and magnitude widths
//   FFT_W          : width of the signed sample word fed to the FFT core
//   sample_offset(): offset-binary midpoint for a given ADC width
`timescale 1ns/1ps
package fft_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN,
    ST_SEARCH,
    ST_DONE
  } fsm_state_t;

  localparam int N_POINTS_DEF  = 1024;
  localparam int AD_W_DEF      = 10;
  localparam int MAG_W_DEF     = 32;
  localparam int SKIP_BINS_DEF = 2;
  localparam int FFT_W         = 16;

  // Offset-binary code that maps to zero after conversion.
  function automatic int sample_offset(input int ad_w);
    return 1 << (ad_w - 1);
  endfunction

  localparam int SAMPLE_OFFSET_DEF = sample_offset(AD_W_DEF);

endpackage

// File: rtl/fft_peak_sched_peak_tracker.sv
// peak_tracker -- running maximum over the magnitude stream of one frame.
//   fft_clk, rst_n : clock, synchronous active-low reset
//   clr            : restart the search (running max 0, index SKIP_BINS)
//   valid, bin, mag: one magnitude beat and its bin number
//   idx_next/max_next : best bin/magnitude including the current beat, so the
//                       caller can capture the final result on the last beat.
// Only bins in [SKIP_BINS, N_POINTS/2) compete; ties keep the lower bin.
`timescale 1ns/1ps
module peak_tracker
  import fft_pkg::*;
#(
  parameter int N_POINTS  = N_POINTS_DEF,
  parameter int MAG_W     = MAG_W_DEF,
  parameter int SKIP_BINS = SKIP_BINS_DEF,
  parameter int BIN_W     = $clog2(N_POINTS)
) (
  input  logic             fft_clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             valid,
  input  logic [BIN_W-1:0] bin,
  input  logic [MAG_W-1:0] mag,
  output logic [BIN_W-1:0] idx_next,
  output logic [MAG_W-1:0] max_next
);

  localparam logic [BIN_W-1:0] SKIP_IDX = BIN_W'(SKIP_BINS);
  localparam logic [BIN_W-1:0] HALF_IDX = BIN_W'(N_POINTS / 2);

  logic [BIN_W-1:0] idx_reg;
  logic [MAG_W-1:0] max_reg;
  logic             in_window;

  // Upper half mirrors the lower half for real input, so it never competes.
  assign in_window = (bin >= SKIP_IDX) && (bin < HALF_IDX);

  always_comb begin
    idx_next = idx_reg;
    max_next = max_reg;
    if (clr) begin
      idx_next = SKIP_IDX;
      max_next = '0;
    end else if (valid && in_window && (mag > max_reg)) begin
      idx_next = bin;
      max_next = mag;
    end
  end

  always_ff @(posedge fft_clk) begin
    if (!rst_n) begin
      idx_reg <= SKIP_IDX;
      max_reg <= '0;
    end else begin
      idx_reg <= idx_next;
      max_reg <= max_next;
    end
  end

endmodule

// File: rtl/fft_peak_sched.sv
// fft_peak_sched -- acquires one ADC frame into an FFT core and reports the
// strongest bin of the returned magnitude stream.
//   fft_clk, rst_n        : clock, synchronous active-low reset
//   start                 : one-cycle request to process one frame (IDLE only)
//   ad_data, ad_valid     : offset-binary ADC samples
//   fft_s_t*              : AXI-stream style sample output to the FFT core
//   mag_data/valid/last   : magnitude stream from the FFT back end, bins 0..N-1
//   peak_bin, peak_mag    : result of the last completed frame, held until next
//   done                  : one-cycle result strobe; busy high outside IDLE
//   err_overrun, err_frame: sticky per-frame error flags, cleared on start
// Assumes AD_W < 16.
`timescale 1ns/1ps
module fft_peak_sched
  import fft_pkg::*;
#(
  parameter int N_POINTS  = N_POINTS_DEF,
  parameter int AD_W      = AD_W_DEF,
  parameter int MAG_W     = MAG_W_DEF,
  parameter int SKIP_BINS = SKIP_BINS_DEF,
  parameter int BIN_W     = $clog2(N_POINTS)
) (
  input  logic             fft_clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AD_W-1:0]  ad_data,
  input  logic             ad_valid,
  output logic [15:0]      fft_s_tdata,
  output logic             fft_s_tvalid,
  output logic             fft_s_tlast,
  input  logic             fft_s_tready,
  input  logic [MAG_W-1:0] mag_data,
  input  logic             mag_valid,
  input  logic             mag_last,
  output logic [BIN_W-1:0] peak_bin,
  output logic [MAG_W-1:0] peak_mag,
  output logic             done,
  output logic             busy,
  output logic             err_overrun,
  output logic             err_frame
);

  localparam logic [BIN_W-1:0] LAST_IDX = BIN_W'(N_POINTS - 1);
  localparam logic [15:0]      OFFSET16 = 16'(sample_offset(AD_W));

  fsm_state_t       state_reg;
  logic [15:0]      hold_data_reg;
  logic             hold_valid_reg;
  logic             tlast_reg;
  logic [BIN_W-1:0] samp_cnt_reg;
  logic             loaded_all_reg;
  logic [BIN_W-1:0] bin_cnt_reg;
  logic [BIN_W-1:0] peak_bin_reg;
  logic [MAG_W-1:0] peak_mag_reg;
  logic             done_reg;
  logic             err_overrun_reg;
  logic             err_frame_reg;

  logic             xfer;
  logic             take_sample;
  logic [15:0]      conv_sample;
  logic             trk_clr;
  logic             trk_valid;
  logic [BIN_W-1:0] trk_idx_next;
  logic [MAG_W-1:0] trk_max_next;

  // Zero-extend then subtract the midpoint; modulo-2^16 wrap yields the
  // sign-extended two's-complement value directly.
  assign conv_sample = {{(16 - AD_W){1'b0}}, ad_data} - OFFSET16;
  assign xfer        = hold_valid_reg && fft_s_tready;
  // The holding register can accept a sample when empty or emptying this cycle.
  // Once all N samples are loaded, further ADC beats are simply ignored.
  assign take_sample = ad_valid && !loaded_all_reg && (!hold_valid_reg || xfer);

  assign trk_clr   = (state_reg == ST_IDLE) && start;
  assign trk_valid = (state_reg == ST_SEARCH) && mag_valid;

  peak_tracker #(
    .N_POINTS  (N_POINTS),
    .MAG_W     (MAG_W),
    .SKIP_BINS (SKIP_BINS),
    .BIN_W     (BIN_W)
  ) u_peak_tracker (
    .fft_clk  (fft_clk),
    .rst_n    (rst_n),
    .clr      (trk_clr),
    .valid    (trk_valid),
    .bin      (bin_cnt_reg),
    .mag      (mag_data),
    .idx_next (trk_idx_next),
    .max_next (trk_max_next)
  );

  always_ff @(posedge fft_clk) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      hold_data_reg   <= '0;
      hold_valid_reg  <= 1'b0;
      tlast_reg       <= 1'b0;
      samp_cnt_reg    <= '0;
      loaded_all_reg  <= 1'b0;
      bin_cnt_reg     <= '0;
      peak_bin_reg    <= '0;
      peak_mag_reg    <= '0;
      done_reg        <= 1'b0;
      err_overrun_reg <= 1'b0;
      err_frame_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg       <= ST_FILL;
            samp_cnt_reg    <= '0;
            loaded_all_reg  <= 1'b0;
            bin_cnt_reg     <= '0;
            hold_valid_reg  <= 1'b0;
            tlast_reg       <= 1'b0;
            err_overrun_reg <= 1'b0;
            err_frame_reg   <= 1'b0;
          end
        end
        ST_FILL: begin
          if (take_sample) begin
            hold_data_reg  <= conv_sample;
            hold_valid_reg <= 1'b1;
            // tlast travels with the sample so it is valid alongside tvalid.
            tlast_reg      <= (samp_cnt_reg == LAST_IDX);
            samp_cnt_reg   <= samp_cnt_reg + 1'b1;
            if (samp_cnt_reg == LAST_IDX) begin
              loaded_all_reg <= 1'b1;
            end
          end else if (xfer) begin
            hold_valid_reg <= 1'b0;
            tlast_reg      <= 1'b0;
          end
          if (ad_valid && !loaded_all_reg && hold_valid_reg && !xfer) begin
            err_overrun_reg <= 1'b1;
          end
          if (xfer && tlast_reg) begin
            state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          bin_cnt_reg <= '0;
          state_reg   <= ST_SEARCH;
        end
        ST_SEARCH: begin
          if (mag_valid) begin
            bin_cnt_reg <= bin_cnt_reg + 1'b1;
            if (mag_last) begin
              if (bin_cnt_reg != LAST_IDX) begin
                err_frame_reg <= 1'b1;
              end
              // Capture through the tracker's next-value path so the final
              // beat is included and the result is visible during DONE.
              peak_bin_reg <= trk_idx_next;
              peak_mag_reg <= trk_max_next;
              done_reg     <= 1'b1;
              state_reg    <= ST_DONE;
            end else if (bin_cnt_reg == LAST_IDX) begin
              err_frame_reg <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign fft_s_tdata  = hold_data_reg;
  assign fft_s_tvalid = hold_valid_reg;
  assign fft_s_tlast  = tlast_reg;
  assign peak_bin     = peak_bin_reg;
  assign peak_mag     = peak_mag_reg;
  assign done         = done_reg;
  assign busy         = (state_reg != ST_IDLE);
  assign err_overrun  = err_overrun_reg;
  assign err_frame    = err_frame_reg;

endmodule

// File: tb/tb_fft_peak_sched.sv
`timescale 1ns/1ps
module tb_fft_peak_sched;

  logic        fft_clk;
  logic        rst_n;
  logic        start;
  logic [9:0]  ad_data;
  logic        ad_valid;
  logic [15:0] fft_s_tdata;
  logic        fft_s_tvalid;
  logic        fft_s_tlast;
  logic        fft_s_tready;
  logic [31:0] mag_data;
  logic        mag_valid;
  logic        mag_last;
  logic [9:0]  peak_bin;
  logic [31:0] peak_mag;
  logic        done;
  logic        busy;
  logic        err_overrun;
  logic        err_frame;

  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  logic [9:0]  done_bin = '0;
  logic [31:0] done_mag = '0;

  fft_peak_sched dut (
    .fft_clk      (fft_clk),
    .rst_n        (rst_n),
    .start        (start),
    .ad_data      (ad_data),
    .ad_valid     (ad_valid),
    .fft_s_tdata  (fft_s_tdata),
    .fft_s_tvalid (fft_s_tvalid),
    .fft_s_tlast  (fft_s_tlast),
    .fft_s_tready (fft_s_tready),
    .mag_data     (mag_data),
    .mag_valid    (mag_valid),
    .mag_last     (mag_last),
    .peak_bin     (peak_bin),
    .peak_mag     (peak_mag),
    .done         (done),
    .busy         (busy),
    .err_overrun  (err_overrun),
    .err_frame    (err_frame)
  );

  initial fft_clk = 1'b0;
  always #5 fft_clk = ~fft_clk;

  // Advance one clock and sample 1 ns after the edge; record any done strobe.
  task automatic tick();
    @(posedge fft_clk);
    #1;
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_bin = peak_bin;
      done_mag = peak_mag;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Hand-chosen magnitude patterns, indexed by bin (stream beats wrap mod 1024).
  function automatic logic [31:0] mag_val(input int mode, input int b);
    int k;
    k = b % 1024;
    case (mode)
      0: begin
        if (k == 0) return 32'd99;
        if (k == 1) return 32'd950;
        if (k == 2) return 32'd6;
        if (k == 51 || k == 52) return 32'd800;
        if (k == 600) return 32'd900;
        return 32'd5;
      end
      1: begin
        if (k == 3) return 32'd200;
        if (k == 100) return 32'd300;
        return 32'd5;
      end
      2: begin
        if (k == 7) return 32'd1234;
        if (k == 511) return 32'd1235;
        if (k == 512) return 32'd5000;
        return 32'd5;
      end
      default: begin
        if (k == 400) return 32'd640;
        if (k == 1023) return 32'd7777;
        return 32'd5;
      end
    endcase
  endfunction

  // Feed ADC samples until target transfers are seen or the cycle budget ends.
  // mode 0: sample every cycle, tready=1; mode 1: sample every 4th cycle,
  // tready high 1 of 4; mode 2: sample every cycle, tready high 1 of 3.
  task automatic fill_frame(input int mode, input int target, output int n_xfer,
                            output int n_data_bad, output int n_last_bad,
                            output logic [15:0] first_data);
    int          cyc;
    int          offered;
    logic        tr;
    logic        av;
    logic [15:0] exp_data;
    cyc = 0;
    offered = 0;
    n_xfer = 0;
    n_data_bad = 0;
    n_last_bad = 0;
    first_data = 16'h1234;
    while (n_xfer < target && cyc < 6000) begin
      tr = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 4 == 3) : (cyc % 3 == 2);
      av = (mode == 1) ? (cyc % 4 == 0) : 1'b1;
      fft_s_tready = tr;
      if (fft_s_tvalid === 1'b1 && tr) begin
        exp_data = 16'(n_xfer - 512);
        if (mode != 2 && fft_s_tdata !== exp_data) n_data_bad = n_data_bad + 1;
        if (n_xfer == 0) first_data = fft_s_tdata;
        if (fft_s_tlast !== (n_xfer == 1023)) n_last_bad = n_last_bad + 1;
        n_xfer = n_xfer + 1;
      end
      ad_valid = av;
      ad_data = 10'(offered);
      if (av) offered = offered + 1;
      tick();
      cyc = cyc + 1;
    end
    ad_valid = 1'b0;
    fft_s_tready = 1'b1;
    $display("frame: mode=%0d transfers=%0d cycles=%0d", mode, n_xfer, cyc);
  endtask

  task automatic send_mags(input int mode, input int n_beats, input int last_idx,
                           input int start_at);
    done_cnt = 0;
    for (int b = 0; b < n_beats; b++) begin
      mag_valid = 1'b1;
      mag_data  = mag_val(mode, b);
      mag_last  = (b == last_idx);
      start     = (b == start_at);
      tick();
    end
    mag_valid = 1'b0;
    mag_last  = 1'b0;
    start     = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    $display("search: mode=%0d beats=%0d done_pulses=%0d bin=%0d mag=%0d",
             mode, n_beats, done_cnt, done_bin, done_mag);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (fft_s_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got %b want 0", fft_s_tvalid); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (peak_bin !== 10'd0 || peak_mag !== 32'd0) begin bad++; $display("FAIL reset_peak: got %0d/%0d want 0/0", peak_bin, peak_mag); end
    total++; if (err_overrun !== 1'b0 || err_frame !== 1'b0) begin bad++; $display("FAIL reset_errs: got %b%b want 00", err_overrun, err_frame); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ramp();
    int nx, nd, nl;
    logic [15:0] fd;
    pulse_start();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ramp_busy: got %b want 1", busy); end
    fill_frame(0, 1024, nx, nd, nl, fd);
    total++; if (nx != 1024) begin bad++; $display("FAIL ramp_xfers: got %0d want 1024", nx); end
    total++; if (nd != 0) begin bad++; $display("FAIL ramp_data: got %0d bad samples want 0", nd); end
    total++; if (nl != 0) begin bad++; $display("FAIL ramp_tlast: got %0d bad tlast want 0", nl); end
    total++; if (fd !== 16'hFE00) begin bad++; $display("FAIL ramp_first: got %h want fe00", fd); end
    total++; if (err_overrun !== 1'b0) begin bad++; $display("FAIL ramp_overrun: got %b want 0", err_overrun); end
    tick();
    tick();
    send_mags(0, 1024, 1023, -1);
    total++; if (done_cnt != 1) begin bad++; $display("FAIL peak_done_pulses: got %0d want 1", done_cnt); end
    total++; if (done_bin !== 10'd51) begin bad++; $display("FAIL peak_bin: got %0d want 51", done_bin); end
    total++; if (done_mag !== 32'd800) begin bad++; $display("FAIL peak_mag: got %0d want 800", done_mag); end
    total++; if (err_frame !== 1'b0) begin bad++; $display("FAIL peak_err_frame: got %b want 0", err_frame); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL peak_idle: got %b want 0", busy); end
    total++; if (peak_bin !== 10'd51 || peak_mag !== 32'd800) begin bad++; $display("FAIL peak_hold: got %0d/%0d want 51/800", peak_bin, peak_mag); end
  endtask

  task automatic test_backpressure();
    int nx, nd, nl;
    logic [15:0] fd;
    pulse_start();
    fill_frame(1, 1024, nx, nd, nl, fd);
    total++; if (nx != 1024) begin bad++; $display("FAIL bp_xfers: got %0d want 1024", nx); end
    total++; if (nd != 0) begin bad++; $display("FAIL bp_data: got %0d bad samples want 0", nd); end
    total++; if (nl != 0) begin bad++; $display("FAIL bp_tlast: got %0d bad tlast want 0", nl); end
    total++; if (err_overrun !== 1'b0) begin bad++; $display("FAIL bp_no_overrun: got %b want 0", err_overrun); end
    tick();
    tick();
    send_mags(0, 1024, 1023, -1);
    total++; if (done_cnt != 1) begin bad++; $display("FAIL bp_done: got %0d want 1", done_cnt); end

    pulse_start();
    fill_frame(2, 1024, nx, nd, nl, fd);
    total++; if (nx != 1024) begin bad++; $display("FAIL ovr_xfers: got %0d want 1024", nx); end
    total++; if (nl != 0) begin bad++; $display("FAIL ovr_tlast: got %0d bad tlast want 0", nl); end
    total++; if (err_overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag: got %b want 1", err_overrun); end
    tick();
    tick();
    send_mags(0, 1024, 1023, -1);
    total++; if (err_overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %b want 1", err_overrun); end
    total++; if (err_frame !== 1'b0) begin bad++; $display("FAIL ovr_err_frame: got %b want 0", err_frame); end
  endtask

  task automatic test_short_frame();
    int nx, nd, nl;
    logic [15:0] fd;
    pulse_start();
    fill_frame(0, 1024, nx, nd, nl, fd);
    total++; if (err_overrun !== 1'b0) begin bad++; $display("FAIL short_overrun_cleared: got %b want 0", err_overrun); end
    tick();
    tick();
    send_mags(1, 701, 700, -1);
    total++; if (done_cnt != 1) begin bad++; $display("FAIL short_done: got %0d want 1", done_cnt); end
    total++; if (err_frame !== 1'b1) begin bad++; $display("FAIL short_err_frame: got %b want 1", err_frame); end
    total++; if (done_bin !== 10'd100 || done_mag !== 32'd300) begin bad++; $display("FAIL short_peak: got %0d/%0d want 100/300", done_bin, done_mag); end
  endtask

  task automatic test_wrap();
    int nx, nd, nl;
    logic [15:0] fd;
    pulse_start();
    fill_frame(0, 1024, nx, nd, nl, fd);
    total++; if (err_frame !== 1'b0) begin bad++; $display("FAIL wrap_err_cleared: got %b want 0", err_frame); end
    tick();
    tick();
    send_mags(1, 1029, 1028, -1);
    total++; if (done_cnt != 1) begin bad++; $display("FAIL wrap_done: got %0d want 1", done_cnt); end
    total++; if (err_frame !== 1'b1) begin bad++; $display("FAIL wrap_err_frame: got %b want 1", err_frame); end
    total++; if (done_bin !== 10'd100) begin bad++; $display("FAIL wrap_peak_bin: got %0d want 100", done_bin); end
  endtask

  task automatic test_reset_mid_fill();
    int nx, nd, nl;
    logic [15:0] fd;
    pulse_start();
    fill_frame(0, 300, nx, nd, nl, fd);
    total++; if (busy !== 1'b1 || fft_s_tvalid !== 1'b1) begin bad++; $display("FAIL midfill_active: got busy=%b tvalid=%b want 1/1", busy, fft_s_tvalid); end
    rst_n = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midfill_busy: got %b want 0", busy); end
    total++; if (fft_s_tvalid !== 1'b0 || fft_s_tlast !== 1'b0) begin bad++; $display("FAIL midfill_stream: got %b%b want 00", fft_s_tvalid, fft_s_tlast); end
    total++; if (peak_bin !== 10'd0 || peak_mag !== 32'd0) begin bad++; $display("FAIL midfill_peak: got %0d/%0d want 0/0", peak_bin, peak_mag); end
    total++; if (err_frame !== 1'b0) begin bad++; $display("FAIL midfill_err: got %b want 0", err_frame); end
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 5; i++) tick();
    total++; if (done_cnt != 0) begin bad++; $display("FAIL midfill_no_done: got %0d want 0", done_cnt); end
    pulse_start();
    fill_frame(0, 1024, nx, nd, nl, fd);
    total++; if (nx != 1024 || nd != 0 || nl != 0) begin bad++; $display("FAIL refill: got xfers=%0d data_bad=%0d last_bad=%0d want 1024/0/0", nx, nd, nl); end
    total++; if (fd !== 16'hFE00) begin bad++; $display("FAIL refill_first: got %h want fe00", fd); end
    tick();
    tick();
    send_mags(2, 1024, 1023, -1);
    total++; if (done_cnt != 1) begin bad++; $display("FAIL refill_done: got %0d want 1", done_cnt); end
    total++; if (done_bin !== 10'd511 || done_mag !== 32'd1235) begin bad++; $display("FAIL refill_peak: got %0d/%0d want 511/1235", done_bin, done_mag); end
    total++; if (err_overrun !== 1'b0 || err_frame !== 1'b0) begin bad++; $display("FAIL refill_errs: got %b%b want 00", err_overrun, err_frame); end
  endtask

  task automatic test_start_in_search();
    int nx, nd, nl;
    logic [15:0] fd;
    pulse_start();
    fill_frame(0, 1024, nx, nd, nl, fd);
    tick();
    tick();
    send_mags(3, 1024, 1023, 500);
    total++; if (done_cnt != 1) begin bad++; $display("FAIL search_start_done: got %0d want 1", done_cnt); end
    total++; if (done_bin !== 10'd400 || done_mag !== 32'd640) begin bad++; $display("FAIL search_start_peak: got %0d/%0d want 400/640", done_bin, done_mag); end
    total++; if (err_frame !== 1'b0) begin bad++; $display("FAIL search_start_err: got %b want 0", err_frame); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL search_start_idle: got %b want 0", busy); end
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    ad_data      = '0;
    ad_valid     = 1'b0;
    fft_s_tready = 1'b1;
    mag_data     = '0;
    mag_valid    = 1'b0;
    mag_last     = 1'b0;
    test_reset();
    test_ramp();
    test_backpressure();
    test_short_frame();
    test_wrap();
    test_reset_mid_fill();
    test_start_in_search();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
